// File: rtl/lib_pkg.sv
// lib_pkg: shared core typedefs; loader_state_t sequences the instruction-memory loader.
package lib_pkg;

    typedef enum logic [2:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI
    } op_type_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_type_t;

    typedef enum logic [1:0] {
        IDLE, LOAD, CHECK, DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory and holds the core in reset until done.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import lib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IADDR = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IADDR:0]   load_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             mem_wr_en,
    output logic [IADDR-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             core_reset_n
);

    localparam logic [IADDR:0] MAX_LEN = (IADDR+1)'(1) << IADDR;

    loader_state_t  state;
    logic [IADDR:0] cnt, len, len_in;

    assign len_in    = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign in_ready  = (state == LOAD) || (state == CHECK);
    assign mem_wr_en = in_valid && (state == LOAD);
    assign mem_addr  = cnt[IADDR-1:0];
    assign mem_wdata = in_data;
    assign busy      = in_ready;
    assign done      = (state == DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;
    logic             err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    // len never exceeds 2**IADDR, so the last accepted address is at most 2**IADDR-1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            core_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            core_reset_n <= (state == DONE) && !start;
            case (state)
                IDLE, DONE: if (start) begin
                    cnt   <= '0;
                    len   <= len_in;
                    state <= (len_in == '0) ? DONE : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum   <= '0;
                    err_q <= 1'b0;
`endif
                end
                LOAD: if (in_valid) begin
                    cnt <= cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= sum + in_data;
                    if (cnt == len - 1'b1) state <= CHECK;
`else
                    if (cnt == len - 1'b1) state <= DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: if (in_valid) begin
                    err_q <= (in_data != sum);
                    state <= DONE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader; inputs change 1ns after posedge,
// outputs are checked mid-cycle and memory writes are logged on the falling edge.
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int IADDR = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [IADDR:0]   load_len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             mem_wr_en;
    logic [IADDR-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             busy;
    logic             done;
    logic             error;
    logic             core_reset_n;

    int checks = 0;
    int errors = 0;

    int          wa[$];
    logic [31:0] wd[$];
    longint      wt[$];

    always #5 clk = ~clk;

    imem_loader #(.WIDTH(WIDTH), .IADDR(IADDR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .core_reset_n(core_reset_n)
    );

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(mem_wdata);
            wt.push_back(longint'($time / 10));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wt.delete();
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = (IADDR+1)'(len);
        step();
        start    = 1'b0;
    endtask

    // Supplies the trailing checksum word when the checksum build is selected.
    task automatic finish_load(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = s;
        #1;
        checks++;
        if (in_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL check_word ready=%b wr_en=%b want 1,0", in_ready, mem_wr_en);
        end
        step();
        in_valid = 1'b0;
`else
        in_data = s;
`endif
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        load_len = '0;
        in_valid = 1'b1;
        in_data  = '0;
        step();
        step();
        checks++;
        if ({busy, done, error, in_ready, core_reset_n, mem_wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {busy, done, error, in_ready, core_reset_n, mem_wr_en});
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs ready=%b done=%b want 0,0", in_ready, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081B3};
        clear_log();
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            #1;
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 5'(i)) begin
                errors++;
                $display("FAIL b2b_load%0d busy=%b ready=%b wr=%b addr=%0d want 1,1,1,%0d",
                         i, busy, in_ready, mem_wr_en, mem_addr, i);
            end
            step();
        end
        in_valid = 1'b0;
        finish_load(32'h0050836C);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || core_reset_n !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done done=%b busy=%b crst=%b err=%b want 1,0,0,0",
                     done, busy, core_reset_n, error);
        end
        step();
        checks++;
        if (core_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL b2b_core_release got %b want 1", core_reset_n);
        end
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", wa.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[i] != i || wd[i] !== w[i] || wt[i] != wt[0] + i) begin
                errors++;
                $display("FAIL b2b_write%0d addr=%0d data=%h t=%0d want %0d,%h,%0d",
                         i, wa[i], wd[i], wt[i], i, w[i], wt[0] + i);
            end
        end
    endtask

    task automatic test_throttle();
        clear_log();
        do_start(3);
        checks++;
        if (core_reset_n !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart crst=%b done=%b want 0,0", core_reset_n, done);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'hA0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        finish_load(32'h1E6);
        checks++;
        if (wa.size() != 3 || done !== 1'b1) begin
            errors++;
            $display("FAIL throttle_count got %0d done=%b want 3,1", wa.size(), done);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wa[i] != i || wd[i] !== 32'hA0 + 32'(2 * i)) begin
                errors++;
                $display("FAIL throttle_write%0d addr=%0d data=%h want %0d,%h",
                         i, wa[i], wd[i], i, 32'hA0 + 32'(2 * i));
            end
        end
    endtask

    task automatic test_clamp();
        clear_log();
        do_start(40);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        finish_load(32'd8688);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clamp_done done=%b busy=%b want 1,0", done, busy);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b0;
        checks++;
        if (wa.size() != 32) begin
            errors++;
            $display("FAIL clamp_count got %0d want 32", wa.size());
        end
        checks++;
        if (wa[31] != 31 || wd[31] !== 32'h11F) begin
            errors++;
            $display("FAIL clamp_last addr=%0d data=%h want 31,0000011f", wa[31], wd[31]);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (wa[i] != i) begin
                errors++;
                $display("FAIL clamp_addr%0d got %0d want %0d", i, wa[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        do_start(4);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        checks++;
        if ({busy, done, in_ready, core_reset_n} !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs got %b want 0000", {busy, done, in_ready, core_reset_n});
        end
        reset_n  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL abort_count got %0d want 2", wa.size());
        end
        clear_log();
        do_start(2);
        in_valid = 1'b1;
        in_data  = 32'h55;
        step();
        in_data  = 32'h66;
        step();
        in_valid = 1'b0;
        finish_load(32'hBB);
        checks++;
        if (wa.size() != 2 || wa[0] != 0 || wa[1] != 1 || wd[0] !== 32'h55 || done !== 1'b1) begin
            errors++;
            $display("FAIL reload n=%0d addr=%0d,%0d d0=%h done=%b want 2,0,1,00000055,1",
                     wa.size(), wa[0], wa[1], wd[0], done);
        end
    endtask

    task automatic test_start_ignore();
        clear_log();
        do_start(3);
        in_valid = 1'b1;
        in_data  = 32'h10;
        step();
        in_data  = 32'h20;
        start    = 1'b1;
        load_len = 6'd1;
        step();
        start    = 1'b0;
        in_data  = 32'h30;
        step();
        in_valid = 1'b0;
        finish_load(32'h60);
        checks++;
        if (wa.size() != 3 || wa[2] != 2 || wd[2] !== 32'h30 || done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start n=%0d addr2=%0d d2=%h done=%b want 3,2,00000030,1",
                     wa.size(), wa[2], wd[2], done);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        clear_log();
        do_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len done=%b busy=%b ready=%b want 1,0,0", done, busy, in_ready);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (core_reset_n !== 1'b1 || wa.size() != 0) begin
            errors++;
            $display("FAIL zero_len_release crst=%b writes=%0d want 1,0", core_reset_n, wa.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            do_start(3);
            for (int i = 1; i <= 3; i++) begin
                in_valid = 1'b1;
                in_data  = 32'(i);
                step();
            end
            in_valid = 1'b0;
            finish_load(32'(6 + k));
            checks++;
            if (error !== 1'(k) || done !== 1'b1) begin
                errors++;
                $display("FAIL checksum%0d err=%b done=%b want %0d,1", k, error, done, k);
            end
            step();
            checks++;
            if (core_reset_n !== 1'b1) begin
                errors++;
                $display("FAIL checksum%0d_release got %b want 1", k, core_reset_n);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_throttle();
        test_clamp();
        test_reset_mid();
        test_start_ignore();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
